// File: rtl/sd_beam_pkg.sv
// Shared types for the beam sequencer: FSM states, beam-index width helper,
// and the delay-line entry tracking which beam's sum is in flight.
package sd_beam_pkg;

  localparam int MAX_BEAM_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int beam_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                  valid;
    logic [MAX_BEAM_W-1:0] beam_idx;
  } dl_entry_t;

endpackage

// File: rtl/sd_beam_cfg_bank.sv
// Double-banked steering table: one write port into a selected bank and a
// combinational full-beam read port from the selected read bank.
module sd_beam_cfg_bank
  import sd_beam_pkg::*;
#(
  parameter int NUM_CH     = 64,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_BEAMS  = 8,
  parameter int BEAM_W     = 3,
  parameter int CH_W       = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic                         wr_bank,
  input  logic [BEAM_W-1:0]            wr_beam,
  input  logic [CH_W-1:0]              wr_ch,
  input  logic [ADDR_WIDTH-1:0]        wr_delay,
  input  logic                         wr_inv,
  input  logic                         rd_bank,
  input  logic [BEAM_W-1:0]            rd_beam,
  output logic [NUM_CH*ADDR_WIDTH-1:0] rd_cmd,
  output logic [NUM_CH-1:0]            rd_inv
);

  localparam int ENTRY_W = ADDR_WIDTH + 1;

  logic [ENTRY_W-1:0] mem [2][NUM_BEAMS][NUM_CH];
  logic               wr_ok;

  assign wr_ok = we && (32'(wr_beam) < NUM_BEAMS) && (32'(wr_ch) < NUM_CH);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NUM_BEAMS; i++)
          for (int c = 0; c < NUM_CH; c++)
            mem[b][i][c] <= '0;
    end else if (wr_ok) begin
      mem[wr_bank][wr_beam][wr_ch] <= {wr_inv, wr_delay};
    end
  end

  // A write landing in the bank being read this cycle (the swap cycle) is forwarded
  // so it is live even for beam 0 of the sweep it coincides with.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rd
    logic fwd;
    assign fwd = wr_ok && (wr_bank == rd_bank) && (wr_beam == rd_beam) && (32'(wr_ch) == gi);
    assign {rd_inv[gi], rd_cmd[gi*ADDR_WIDTH +: ADDR_WIDTH]} =
      fwd ? {wr_inv, wr_delay} : mem[rd_bank][rd_beam][gi];
  end

endmodule

// File: rtl/sd_beam_sequencer.sv
// Sweeps NUM_BEAMS steering configurations through one delay-and-sum datapath per sample.
// Optional SD_BEAM_TIMESTAMP_EN adds beam_ts, the accepted-sample count latched per sweep.
module sd_beam_sequencer
  import sd_beam_pkg::*;
#(
  parameter int NUM_CH     = 64,
  parameter int ADDR_WIDTH = 8,
  parameter int OUT_WIDTH  = 16,
  parameter int OUT_DELAY  = 3,
  parameter int NUM_BEAMS  = 8,
  parameter int TS_WIDTH   = 16,
  localparam int BEAM_W    = beam_w(NUM_BEAMS),
  localparam int CH_W      = beam_w(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample,
  input  logic                         cfg_we,
  input  logic [BEAM_W-1:0]            cfg_beam,
  input  logic [CH_W-1:0]              cfg_ch,
  input  logic [ADDR_WIDTH-1:0]        cfg_delay,
  input  logic                         cfg_inv,
  input  logic                         cfg_commit,
  input  logic                         ovr_clr,
  output logic [NUM_CH*ADDR_WIDTH-1:0] cmd_out,
  output logic [NUM_CH-1:0]            inv_out,
  input  logic [OUT_WIDTH-1:0]         bf_data,
  output logic                         beam_valid,
  output logic [BEAM_W-1:0]            beam_idx,
  output logic [OUT_WIDTH-1:0]         beam_data,
  output logic                         sweep_done,
  output logic                         busy,
  output logic                         commit_pending,
  output logic                         active_bank,
`ifdef SD_BEAM_TIMESTAMP_EN
  output logic [TS_WIDTH-1:0]          beam_ts,
`endif
  output logic                         overrun
);

  state_t                        state_reg, state_next;
  logic [BEAM_W-1:0]             k_reg, k_next;
  logic                          drive;
  logic                          ovr_event, swap, rd_bank, capture, pipe_empty_next;
  logic [BEAM_W-1:0]             rd_beam;
  logic [NUM_CH*ADDR_WIDTH-1:0]  rd_cmd;
  logic [NUM_CH-1:0]             rd_inv;
  // pipe_reg[0] is aligned with cmd_out; pipe_reg[OUT_DELAY] with the valid bf_data.
  dl_entry_t                     pipe_reg [OUT_DELAY+1];

  assign ovr_event = sample && (state_reg != IDLE);
  assign swap      = sample && (commit_pending || cfg_commit);
  assign rd_bank   = swap ? ~active_bank : active_bank;
  assign rd_beam   = sample ? '0 : k_reg;
  assign capture   = pipe_reg[OUT_DELAY].valid && !ovr_event;
  assign busy      = (state_reg != IDLE);

  sd_beam_cfg_bank #(
    .NUM_CH     (NUM_CH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_BEAMS  (NUM_BEAMS),
    .BEAM_W     (BEAM_W),
    .CH_W       (CH_W)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .we       (cfg_we),
    .wr_bank  (~active_bank),
    .wr_beam  (cfg_beam),
    .wr_ch    (cfg_ch),
    .wr_delay (cfg_delay),
    .wr_inv   (cfg_inv),
    .rd_bank  (rd_bank),
    .rd_beam  (rd_beam),
    .rd_cmd   (rd_cmd),
    .rd_inv   (rd_inv)
  );

  always_comb begin
    pipe_empty_next = 1'b1;
    for (int i = 0; i < OUT_DELAY; i++)
      if (pipe_reg[i].valid) pipe_empty_next = 1'b0;
  end

  // Accepting a sample drives beam 0 immediately, so DRIVE starts at beam 1.
  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    drive      = 1'b0;
    if (sample) begin
      drive      = 1'b1;
      k_next     = BEAM_W'(1);
      state_next = (NUM_BEAMS > 1) ? DRIVE : DRAIN;
    end else begin
      case (state_reg)
        DRIVE: begin
          drive  = 1'b1;
          k_next = k_reg + BEAM_W'(1);
          if (32'(k_reg) == NUM_BEAMS - 1) state_next = DRAIN;
        end
        DRAIN: if (pipe_empty_next) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      k_reg          <= '0;
      for (int i = 0; i <= OUT_DELAY; i++) pipe_reg[i] <= '0;
      cmd_out        <= '0;
      inv_out        <= '0;
      beam_valid     <= 1'b0;
      beam_idx       <= '0;
      beam_data      <= '0;
      sweep_done     <= 1'b0;
      active_bank    <= 1'b0;
      commit_pending <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      if (drive) begin
        cmd_out <= rd_cmd;
        inv_out <= rd_inv;
      end
      pipe_reg[0] <= '{valid: drive, beam_idx: MAX_BEAM_W'(rd_beam)};
      for (int i = 1; i <= OUT_DELAY; i++)
        pipe_reg[i] <= ovr_event ? '0 : pipe_reg[i-1];
      beam_valid <= capture;
      sweep_done <= capture && (32'(pipe_reg[OUT_DELAY].beam_idx) == NUM_BEAMS - 1);
      if (capture) begin
        beam_idx  <= pipe_reg[OUT_DELAY].beam_idx[BEAM_W-1:0];
        beam_data <= bf_data;
      end
      if (swap) active_bank <= ~active_bank;
      if (swap)            commit_pending <= 1'b0;
      else if (cfg_commit) commit_pending <= 1'b1;
      if (ovr_event)    overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

`ifdef SD_BEAM_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt_reg, sweep_ts_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt_reg   <= '0;
      sweep_ts_reg <= '0;
      beam_ts      <= '0;
    end else begin
      if (sample) begin
        sweep_ts_reg <= ts_cnt_reg;
        ts_cnt_reg   <= ts_cnt_reg + TS_WIDTH'(1);
      end
      if (capture) beam_ts <= sweep_ts_reg;
    end
  end
`endif

endmodule

// File: tb/tb_sd_beam_sequencer.sv
// Scoreboard bench for sd_beam_sequencer with a delayed datapath model on cmd_out/inv_out.
module tb_sd_beam_sequencer;

  localparam int NUM_CH = 64;
  localparam int AW     = 8;
  localparam int OW     = 16;
  localparam int D      = 3;
  localparam int NB     = 8;
  localparam int TSW    = 4;
  localparam int BW     = 3;
  localparam int CW     = 6;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  sample = 1'b0;
  logic                  cfg_we = 1'b0;
  logic [BW-1:0]         cfg_beam = '0;
  logic [CW-1:0]         cfg_ch = '0;
  logic [AW-1:0]         cfg_delay = '0;
  logic                  cfg_inv = 1'b0;
  logic                  cfg_commit = 1'b0;
  logic                  ovr_clr = 1'b0;
  logic [NUM_CH*AW-1:0]  cmd_out;
  logic [NUM_CH-1:0]     inv_out;
  logic [OW-1:0]         bf_data;
  logic                  beam_valid;
  logic [BW-1:0]         beam_idx;
  logic [OW-1:0]         beam_data;
  logic                  sweep_done;
  logic                  busy;
  logic                  commit_pending;
  logic                  active_bank;
  logic                  overrun;
`ifdef SD_BEAM_TIMESTAMP_EN
  logic [TSW-1:0]        beam_ts;
`endif

  sd_beam_sequencer #(
    .NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .OUT_WIDTH(OW), .OUT_DELAY(D),
    .NUM_BEAMS(NB), .TS_WIDTH(TSW)
  ) dut (
    .clk(clk), .rst(rst), .sample(sample),
    .cfg_we(cfg_we), .cfg_beam(cfg_beam), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay),
    .cfg_inv(cfg_inv), .cfg_commit(cfg_commit), .ovr_clr(ovr_clr),
    .cmd_out(cmd_out), .inv_out(inv_out), .bf_data(bf_data),
    .beam_valid(beam_valid), .beam_idx(beam_idx), .beam_data(beam_data),
    .sweep_done(sweep_done), .busy(busy), .commit_pending(commit_pending),
    .active_bank(active_bank),
`ifdef SD_BEAM_TIMESTAMP_EN
    .beam_ts(beam_ts),
`endif
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Datapath stand-in: sum valid OUT_DELAY cycles after cmd/inv change.
  logic [OW-1:0] dp [D];
  function automatic logic [OW-1:0] dp_f(input logic [NUM_CH*AW-1:0] c, input logic [NUM_CH-1:0] iv);
    return 16'(100 * c[7:0]) + 16'(c[47:40]) + (iv[5] ? 16'd1000 : 16'd0);
  endfunction
  always @(posedge clk) begin
    dp[0] <= dp_f(cmd_out, inv_out);
    for (int i = 1; i < D; i++) dp[i] <= dp[i-1];
  end
  assign bf_data = dp[D-1];

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int acc_cnt  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    int cyc;
    int idx;
    int data;
    bit done;
    int ts;
  } exp_t;
  exp_t sbq[$];

  always @(negedge clk) begin
    exp_t e;
    if (beam_valid) begin
      $display("beam result cyc=%0d idx=%0d data=%0d done=%0b", cyc, beam_idx, beam_data, sweep_done);
      if (sbq.size() == 0) begin
        chk("unexpected_beam_valid", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("beam_cycle", cyc, e.cyc);
        chk("beam_idx", beam_idx, e.idx);
        chk("beam_data", beam_data, e.data);
        chk("sweep_done", sweep_done, e.done);
`ifdef SD_BEAM_TIMESTAMP_EN
        chk("beam_ts", beam_ts, e.ts);
`endif
      end
    end else if (sweep_done) begin
      chk("sweep_done_without_valid", 1, 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_sweep(input int t, input int data[NB], input int n, input int ts);
    for (int k = 0; k < n; k++)
      sbq.push_back('{cyc: t + 2 + k + D, idx: k, data: data[k], done: (k == NB - 1), ts: ts});
  endtask

  // Raises sample for one cycle; returns at T+1.
  task automatic sweep_start(input int data[NB], input int n);
    push_sweep(cyc, data, n, acc_cnt % 16);
    sample = 1'b1;
    tick(1);
    sample = 1'b0;
    acc_cnt++;
  endtask

  task automatic wr(input int b, input int c, input int dly, input bit iv);
    cfg_we = 1'b1; cfg_beam = BW'(b); cfg_ch = CW'(c); cfg_delay = AW'(dly); cfg_inv = iv;
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick(1);
    cfg_commit = 1'b0;
  endtask

  int d_zero[NB], d_lin[NB], d_t2[NB], d_t5[NB];

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NB; k++) begin
      d_zero[k] = 0;
      d_lin[k]  = k * 100;
      d_t2[k]   = k * 100;
      d_t5[k]   = k * 100;
    end
    d_t2[2] = 200 + 58 + 1000;
    d_t5[0] = 17 + 1000;

    tick(3);
    rst = 1'b0;
    tick(1);
    chk("reset_cmd_out", (cmd_out == '0), 1);
    chk("reset_inv_out", inv_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_commit_pending", commit_pending, 0);
    chk("reset_active_bank", active_bank, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_beam_valid", beam_valid, 0);

    // Sweep on cleared banks.
    sweep_start(d_zero, NB);
    chk("busy_in_sweep", busy, 1);
    tick(NB + D - 1);
    chk("busy_before_end", busy, 1);
    tick(1);
    chk("busy_after_sweep", busy, 0);

    // Beam k ch0 = k into shadow bank 1, commit, expect k*100.
    for (int k = 0; k < NB; k++) wr(k, 0, k, 0);
    chk("bank_before_commit", active_bank, 0);
    commit();
    chk("commit_pending_set", commit_pending, 1);
    sweep_start(d_lin, NB);
    chk("active_bank_swapped", active_bank, 1);
    chk("commit_pending_cleared", commit_pending, 0);
    tick(NB + D);

    // Shadow write without commit stays invisible.
    wr(2, 5, 8'h3A, 1);
    sweep_start(d_lin, NB);
    for (int k = 0; k < NB; k++) begin
      chk("nocommit_cmd_ch5", cmd_out[47:40], 0);
      tick(1);
    end
    tick(D);

    // Same write plus ch0 pattern into bank 0, then commit.
    for (int k = 0; k < NB; k++) wr(k, 0, k, 0);
    wr(2, 5, 8'h3A, 1);
    commit();
    sweep_start(d_t2, NB);
    tick(1);
    chk("beam1_cmd_ch5", cmd_out[47:40], 0);
    tick(1);
    chk("beam2_cmd_ch5", cmd_out[47:40], 8'h3A);
    chk("beam2_inv_ch5", inv_out[5], 1);
    tick(1);
    chk("beam3_cmd_ch5", cmd_out[47:40], 0);
    tick(NB + D - 3);

    // Overrun: second sample at T+6 keeps only beams 0 and 1 of the first sweep.
    sweep_start(d_t2, 2);
    tick(5);
    sweep_start(d_t2, NB);
    chk("overrun_set", overrun, 1);
    tick(NB + D);
    chk("overrun_sticky", overrun, 1);
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    chk("overrun_cleared", overrun, 0);

    // Overrun coinciding with ovr_clr: set wins; the first sweep yields nothing.
    sweep_start(d_t2, 0);
    tick(1);
    ovr_clr = 1'b1;
    sweep_start(d_t2, NB);
    ovr_clr = 1'b0;
    chk("overrun_set_wins", overrun, 1);
    tick(NB + D);

    // Same-cycle write, commit and sample: beam 0 ch5 written into bank 1 is live.
    cfg_we = 1'b1; cfg_beam = 3'd0; cfg_ch = 6'd5; cfg_delay = 8'h11; cfg_inv = 1'b1;
    cfg_commit = 1'b1;
    sweep_start(d_t5, NB);
    cfg_we = 1'b0; cfg_commit = 1'b0;
    chk("samecycle_bank", active_bank, 1);
    chk("samecycle_cmd_ch5", cmd_out[47:40], 8'h11);
    tick(NB + D);

    // Reset and run 17 sweeps; the timestamp wraps to 0 on the 17th.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    acc_cnt = 0;
    chk("rereset_active_bank", active_bank, 0);
    for (int s = 0; s < 17; s++) begin
      sweep_start(d_zero, NB);
      tick(NB + D);
    end

    for (int i = 0; i < 100 && sbq.size() != 0; i++) tick(1);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
